// File: rtl/divu_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM encoding, default widths and ready polarity.
package divu_pkg;

    localparam int X_WIDTH_DEF = 4;
    localparam int Y_WIDTH_DEF = 2;
    localparam logic READY_TRUE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step.
// Shifts in the next dividend bit and conditionally subtracts the divisor.
module divu_step #(
    parameter int Y_WIDTH = 2
) (
    input  logic [Y_WIDTH:0]   rem_i,
    input  logic               bit_i,
    input  logic [Y_WIDTH-1:0] div_i,
    output logic [Y_WIDTH:0]   rem_o,
    output logic               q_o
);

    logic [Y_WIDTH:0]   shifted;
    logic [Y_WIDTH+1:0] trial;

    // A set top remainder bit means the shifted value already exceeds any divisor.
    always_comb begin
        shifted = {rem_i[Y_WIDTH-1:0], bit_i};
        trial   = {1'b0, shifted} - {2'b00, div_i};
        q_o     = rem_i[Y_WIDTH] | ~trial[Y_WIDTH+1];
        rem_o   = q_o ? trial[Y_WIDTH:0] : shifted;
    end

endmodule

// File: rtl/divu_x4y2_seq.sv
// Sequential unsigned divider: one restoring step per cycle.
// Handshake via start/rdy, one-cycle valid pulse with registered results.
module divu_x4y2_seq
    import divu_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_DEF,
    parameter int Y_WIDTH = Y_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    output logic [X_WIDTH-1:0] q,
    output logic [Y_WIDTH-1:0] r,
    output logic               dbz,
    output logic               rdy,
    output logic               valid
);

    localparam int CW = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(X_WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [X_WIDTH-1:0] quot_q, quot_d;
    logic [Y_WIDTH:0]   rem_q, rem_d;
    logic [Y_WIDTH-1:0] div_q, div_d;
    logic               dz_q, dz_d;
    logic [X_WIDTH-1:0] q_q, q_d;
    logic [Y_WIDTH-1:0] r_q, r_d;
    logic               dbz_q, dbz_d;

    logic [Y_WIDTH:0]   step_rem;
    logic               step_q;
    logic [X_WIDTH-1:0] quot_next;

    divu_step #(
        .Y_WIDTH(Y_WIDTH)
    ) u_step (
        .rem_i(rem_q),
        .bit_i(quot_q[X_WIDTH-1]),
        .div_i(div_q),
        .rem_o(step_rem),
        .q_o  (step_q)
    );

    assign quot_next = (quot_q << 1) | X_WIDTH'(step_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div_d   = div_q;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    quot_d  = x;
                    div_d   = y;
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    dz_d    = (y == '0);
                end
            end
            CALC: begin
                rem_d  = step_rem;
                quot_d = quot_next;
                cnt_d  = cnt_q - 1'b1;
                // Results are published only on the final step.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    q_d     = dz_q ? '1 : quot_next;
                    r_d     = dz_q ? '0 : step_rem[Y_WIDTH-1:0];
                    dbz_d   = dz_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign rdy   = (state_q == CALC) ? ~READY_TRUE : READY_TRUE;
    assign valid = (state_q == DONE);
    assign q     = q_q;
    assign r     = r_q;
    assign dbz   = dbz_q;

endmodule

// File: tb/tb_divu_x4y2_seq.sv
// Scoreboard bench for divu_x4y2_seq at X_WIDTH=4, Y_WIDTH=2.
// Expected results are queued at issue and popped when valid arrives.
module tb_divu_x4y2_seq;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] r;
        logic       dbz;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [1:0] y;
    logic [3:0] q;
    logic [1:0] r;
    logic       dbz;
    logic       rdy;
    logic       valid;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    divu_x4y2_seq #(
        .X_WIDTH(4),
        .Y_WIDTH(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .q    (q),
        .r    (r),
        .dbz  (dbz),
        .rdy  (rdy),
        .valid(valid)
    );

    function automatic res_t ref_div(int a, int b);
        res_t e;
        if (b == 0) begin
            e.q = 4'hF;
            e.r = 2'd0;
            e.dbz = 1'b1;
        end else begin
            e.q = 4'(a / b);
            e.r = 2'(a % b);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int a, int b);
        x = 4'(a);
        y = 2'(b);
        start = 1'b1;
        sb.push_back(ref_div(a, b));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (valid === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        x = 4'd13;
        y = 2'd3;
        tick();
        tick();
        n_vec++;
        if ({rdy, valid, q, r, dbz} !== 9'b1_0_0000_00_0) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b valid=%b q=%0d r=%0d dbz=%b want 1 0 0 0 0",
                     rdy, valid, q, r, dbz);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        n_vec++;
        if ({rdy, valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_start_priority got rdy=%b valid=%b want 1 0", rdy, valid);
        end
    endtask

    task automatic test_basic();
        int   xs[3] = '{13, 2, 15};
        int   ys[3] = '{3, 3, 1};
        int   lat;
        res_t e;
        for (int i = 0; i < 3; i++) begin
            issue(xs[i], ys[i]);
            wait_valid(lat);
            e = sb.pop_front();
            n_vec++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL basic_latency %0d/%0d got %0d want 4", xs[i], ys[i], lat);
            end
            n_vec++;
            if ({q, r, dbz, rdy} !== {e, 1'b1}) begin
                n_err++;
                $display("FAIL basic_result %0d/%0d got q=%0d r=%0d dbz=%b rdy=%b want q=%0d r=%0d dbz=%b rdy=1",
                         xs[i], ys[i], q, r, dbz, rdy, e.q, e.r, e.dbz);
            end
            tick();
            n_vec++;
            if ({valid, q, r, dbz} !== {1'b0, e}) begin
                n_err++;
                $display("FAIL basic_hold %0d/%0d got valid=%b q=%0d r=%0d want valid=0 q=%0d r=%0d",
                         xs[i], ys[i], valid, q, r, e.q, e.r);
            end
        end
    endtask

    task automatic test_sweep();
        int   lat;
        res_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                issue(a, b);
                wait_valid(lat);
                e = sb.pop_front();
                n_vec++;
                if (lat !== 4 || {q, r, dbz} !== e) begin
                    n_err++;
                    $display("FAIL sweep %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b want lat=4 q=%0d r=%0d dbz=%b",
                             a, b, lat, q, r, dbz, e.q, e.r, e.dbz);
                end
            end
        end
    endtask

    task automatic test_dbz();
        int   lat;
        res_t e;
        issue(9, 0);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL dbz_9_0 got lat=%0d q=%0d r=%0d dbz=%b want lat=4 q=15 r=0 dbz=1",
                     lat, q, r, dbz);
        end
        tick();
        issue(9, 3);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL dbz_clear_9_3 got lat=%0d q=%0d r=%0d dbz=%b want lat=4 q=3 r=0 dbz=0",
                     lat, q, r, dbz);
        end
    endtask

    task automatic test_ignore_start();
        int   lat;
        res_t e;
        x = 4'd11;
        y = 2'd2;
        start = 1'b1;
        sb.push_back(ref_div(11, 2));
        tick();
        for (int i = 0; i < 3; i++) begin
            x = 4'($urandom);
            y = 2'($urandom);
            tick();
        end
        x = 4'd14;
        y = 2'd3;
        sb.push_back(ref_div(14, 3));
        tick();
        e = sb.pop_front();
        n_vec++;
        if ({valid, q, r, dbz} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL ignore_start got valid=%b q=%0d r=%0d dbz=%b want valid=1 q=%0d r=%0d dbz=%b",
                     valid, q, r, dbz, e.q, e.r, e.dbz);
        end
        tick();
        start = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL ignore_start_b2b got lat=%0d q=%0d r=%0d want lat=4 q=%0d r=%0d",
                     lat, q, r, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        res_t e;
        issue(5, 2);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want lat=4 q=2 r=1", lat, q, r);
        end
        issue(15, 2);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want lat=4 q=7 r=1", lat, q, r);
        end
        tick();
    endtask

    task automatic test_rst_abort();
        int   lat;
        bit   seen;
        res_t e;
        issue(13, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_vec++;
        if ({rdy, valid, q, r, dbz} !== 9'b1_0_0000_00_0) begin
            n_err++;
            $display("FAIL abort_state got rdy=%b valid=%b q=%0d r=%0d dbz=%b want 1 0 0 0 0",
                     rdy, valid, q, r, dbz);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_valid got pulse=%b want 0", seen);
        end
        issue(7, 2);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 4 || {q, r, dbz} !== e) begin
            n_err++;
            $display("FAIL abort_next_7_2 got lat=%0d q=%0d r=%0d want lat=4 q=3 r=1", lat, q, r);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        test_reset();
        test_basic();
        test_sweep();
        test_dbz();
        test_ignore_start();
        test_back_to_back();
        test_rst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divu_x4y2_seq.md
DIVU_X4Y2_SEQ -- requirements
Module: divu_x4y2_seq

Interface
REQ-001 Parameter X_WIDTH, default 4, dividend and quotient width.
REQ-002 Parameter Y_WIDTH, default 2, divisor and remainder width (Y_WIDTH <= X_WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; accepted on a clk edge where start=1 and rdy=1.
REQ-006 x  input  X_WIDTH  unsigned dividend; sampled only at accept.
REQ-007 y  input  Y_WIDTH  unsigned divisor; sampled only at accept.
REQ-008 q  output  X_WIDTH  unsigned quotient, registered.
REQ-009 r  output  Y_WIDTH  unsigned remainder, registered.
REQ-010 dbz  output  1  divide-by-zero flag for current result, registered.
REQ-011 rdy  output  1  high when block can accept start (READY_TRUE polarity = 1).
REQ-012 valid  output  1  one-cycle pulse marking q/r/dbz as new result.

Function
REQ-013 FSM states IDLE, CALC, DONE shall be the only states; encoding from shared package.
REQ-014 IDLE: rdy=1, valid=0; accept -> CALC, latch x into quotient shift register, y into divisor register, clear partial remainder (Y_WIDTH+1 bits), load step counter = X_WIDTH-1.
REQ-015 CALC: rdy=0; each cycle one restoring step: shift {rem,quot} left 1, trial = rem - divisor; if trial non-negative rem=trial and quot LSB=1, else quot LSB=0.
REQ-016 CALC lasts exactly X_WIDTH cycles; on the edge where counter=0 the step completes and state -> DONE.
REQ-017 Latency: accept at edge k -> valid=1 during the cycle after edge k+X_WIDTH, i.e. X_WIDTH+1 edges from accept to valid.
REQ-018 DONE: valid=1 for exactly one cycle, rdy=1; next edge -> IDLE, or straight to CALC if start=1 (back-to-back accept).
REQ-019 q, r, dbz shall update only on the transition into DONE and hold until the next transition into DONE or reset.
REQ-020 Result shall satisfy x = q*y + r with r < y for every y != 0.
REQ-021 y=0: dbz=1, q=all ones, r=0, same latency and handshake as normal divide; dbz=0 otherwise.
REQ-022 start while in CALC shall be ignored: no effect on operands, counter or result.
REQ-023 x, y changing during CALC shall not affect the result.
REQ-024 Remainder arithmetic shall use Y_WIDTH+1 bits so that no trial subtraction overflows; no truncation of quotient bits.

Reset
REQ-025 rst=1 at an edge shall force state=IDLE, q=0, r=0, dbz=0, valid=0, rdy=1 in the following cycle, from any state.
REQ-026 rst asserted mid-CALC shall abort the operation; no valid pulse for the aborted request.
REQ-027 rst has priority over start; start with rst=1 is not accepted.

Structure
REQ-028 Shared package divu_pkg shall hold the state enum (IDLE, CALC, DONE), default X_WIDTH/Y_WIDTH, and READY_TRUE.
REQ-029 One sub-module divu_step shall implement the combinational restoring step (inputs rem, next dividend bit, divisor; outputs new rem, quotient bit), instantiated once in the datapath.
REQ-030 Control (FSM + counter) and datapath registers shall reside in divu_x4y2_seq; no latches, no combinational path from start to rdy or valid.

Verification (X_WIDTH=4, Y_WIDTH=2)
REQ-031 x=13, y=3, start pulse -> after 5 edges valid=1 for one cycle, q=4, r=1, dbz=0.
REQ-032 x=2, y=3 -> q=0, r=2; x=15, y=1 -> q=15, r=0; exhaustive 16x4 sweep matches reference x/y, x%y.
REQ-033 x=9, y=0 -> valid after 5 edges, q=15, r=0, dbz=1; next divide 9/3 -> q=3, r=0, dbz=0.
REQ-034 start held high during CALC with changing x/y -> ignored, result equals originally sampled operands; start high in DONE -> back-to-back result 5 edges later.
REQ-035 rst pulsed 2 cycles into CALC -> next cycle IDLE, rdy=1, q=r=0, no valid pulse; new 7/2 afterwards -> q=3, r=1.
